// File: rtl/host_averager_pkg.sv
// Shared widths, count limit and packed snapshot layout for the host averager.
// Latency: none (package only).
// Backpressure: none (package only).
package host_averager_pkg;

    // Default sample width and sample-count width.
    localparam int DW_DEF = 24;
    localparam int CW_DEF = 8;

    // Largest representable sample count for a given count width.
    function automatic int npt_max(input int cw);
        return (1 << cw) - 1;
    endfunction

    // Count ceiling for the default count width (255).
    localparam int NPT_MAX = npt_max(CW_DEF);

    // data_out field offsets: npt in the low CW bits, average directly above it.
    localparam int NPT_LSB = 0;
    localparam int AVG_LSB = NPT_LSB + CW_DEF;
    localparam int OUT_W   = DW_DEF + CW_DEF;

    // Snapshot layout at default widths.
    typedef struct packed {
        logic [DW_DEF-1:0] avg;
        logic [CW_DEF-1:0] npt;
    } snap_t;

endpackage

// File: rtl/host_averager_acc.sv
// Saturating sample accumulator: running sum and sample count, restartable.
// Latency: sum/count reflect a strobed sample one clk edge later.
// Backpressure: none; once the count saturates further samples are dropped.
module host_averager_acc
    import host_averager_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               restart_i,
    input  logic               sample_i,
    input  logic [DW-1:0]      data_i,
    output logic [DW+CW-1:0]   sum_o,
    output logic [CW-1:0]      cnt_o
);

    // Count ceiling; the sum can never wrap because
    // (2^CW-1)*(2^DW-1) < 2^(DW+CW).
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [DW+CW-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DW+CW-1:0] data_ext;
    logic             sat;

    assign data_ext = {{CW{1'b0}}, data_i};
    assign sat      = (cnt_q == CNT_MAX);

    // Next-state: a restart opens a new interval, seeded with the sample of
    // that same cycle if one is present; otherwise accumulate until saturated.
    always_comb begin
        sum_d = sum_q;
        cnt_d = cnt_q;
        if (restart_i) begin
            if (sample_i) begin
                sum_d = data_ext;
                cnt_d = CW'(1);
            end else begin
                sum_d = '0;
                cnt_d = '0;
            end
        end else if (sample_i && !sat) begin
            sum_d = sum_q + data_ext;
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Accumulator state, cleared asynchronously so no pre-reset sample survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
            cnt_q <= '0;
        end else begin
            sum_q <= sum_d;
            cnt_q <= cnt_d;
        end
    end

    assign sum_o = sum_q;
    assign cnt_o = cnt_q;

endmodule

// File: rtl/host_averager.sv
// Host-read sample averager: snapshots {average, count} on read_s and restarts.
// Latency: data_out valid one clk edge after read_s; held until the next read.
// Backpressure: none; samples beyond the count ceiling are dropped.
// Build option: define HOST_AVERAGER_ROUND_EN for round-half-up averaging
// (saturated to the average width); default build truncates.
module host_averager
    import host_averager_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DW-1:0]      data_in,
    input  logic               data_s,
    input  logic               read_s,
    output logic [DW+CW-1:0]   data_out
);

    logic [DW+CW-1:0] sum;
    logic [CW-1:0]    cnt;
    logic [DW-1:0]    avg;
    logic [DW+CW-1:0] data_out_q, data_out_d;

    // The read strobe doubles as the accumulator restart, so the snapshot
    // below sees the pre-edge interval while the accumulator starts afresh.
    host_averager_acc #(
        .DW (DW),
        .CW (CW)
    ) u_acc (
        .clk       (clk),
        .rst       (rst),
        .restart_i (read_s),
        .sample_i  (data_s),
        .data_i    (data_in),
        .sum_o     (sum),
        .cnt_o     (cnt)
    );

`ifdef HOST_AVERAGER_ROUND_EN
    // Half an LSB of the average, added before the shift; one extra bit of
    // headroom lets the rounded result exceed the field so it can be clamped.
    localparam logic [DW+CW:0] HALF = (DW+CW+1)'(1) << (CW - 1);
    logic [DW:0] avg_wide;

    // Round half up, then clamp to the largest representable average.
    always_comb begin
        avg_wide = (DW+1)'(({1'b0, sum} + HALF) >> CW);
        avg      = avg_wide[DW] ? {DW{1'b1}} : avg_wide[DW-1:0];
    end
`else
    // Truncated average: drop the CW fractional bits of the sum.
    always_comb begin
        avg = DW'(sum >> CW);
    end
`endif

    // Snapshot next-state: load on a read, otherwise hold.
    always_comb begin
        data_out_d = data_out_q;
        if (read_s) begin
            data_out_d = {avg, cnt};
        end
    end

    // Snapshot register; an empty interval naturally packs to all zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_q <= '0;
        end else begin
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_host_averager.sv
// Directed self-checking bench for host_averager (default DW=24, CW=8).
// Honors HOST_AVERAGER_ROUND_EN when the design is built with it.
module tb_host_averager;

    localparam int DW = 24;
    localparam int CW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   data_in;
    logic            data_s;
    logic            read_s;
    logic [DW+CW-1:0] data_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    host_averager #(
        .DW (DW),
        .CW (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .data_s   (data_s),
        .read_s   (read_s),
        .data_out (data_out)
    );

    function automatic logic [DW+CW-1:0] pack(input logic [DW-1:0] avg, input logic [CW-1:0] npt);
        return {avg, npt};
    endfunction

    // Reference average of an accumulated sum.
    function automatic logic [DW-1:0] avg_of(input longint unsigned s);
        longint unsigned r;
`ifdef HOST_AVERAGER_ROUND_EN
        r = (s + 64'd128) >> 8;
        if (r > 64'hFF_FFFF) r = 64'hFF_FFFF;
`else
        r = s >> 8;
`endif
        return r[DW-1:0];
    endfunction

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [DW-1:0] v);
        data_in = v;
        data_s  = 1'b1;
        read_s  = 1'b0;
        tick();
        data_s  = 1'b0;
    endtask

    task automatic do_read();
        data_s = 1'b0;
        read_s = 1'b1;
        tick();
        read_s = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; data_in = '0; data_s = 1'b0; read_s = 1'b0;
        #12;
        checks++;
        if (data_out !== '0) begin
            errors++;
            $display("FAIL reset_value: got %h expected %h", data_out, {(DW+CW){1'b0}});
        end
        tick();
        rst = 1'b0;
        tick();
        do_read();
        checks++;
        if (data_out !== '0) begin
            errors++;
            $display("FAIL empty_read: got %h expected %h", data_out, {(DW+CW){1'b0}});
        end
    endtask

    task automatic test_periodic();
        longint unsigned msum = 0;
        int              mcnt = 0;
        logic [DW+CW-1:0] exp_q = '0;
        logic [DW-1:0]   prev_avg = '0;
        logic [CW-1:0]   prev_npt = '0;
        logic [DW-1:0]   hand_avg;
        int              reads = 0;
        do_read();
        for (int c = 0; c < 188 * 12; c++) begin
            data_in = 24'd88888;
            data_s  = (c % 5 == 0);
            read_s  = (c % 188 == 187);
            if (read_s) begin
                checks++;
                if (data_out !== exp_q) begin
                    errors++;
                    $display("FAIL hold_between_reads: got %h expected %h", data_out, exp_q);
                end
                exp_q = pack(avg_of(msum), CW'(mcnt));
                msum  = data_s ? 64'(data_in) : 64'd0;
                mcnt  = data_s ? 1 : 0;
            end else if (data_s && mcnt < 255) begin
                msum += 64'(data_in);
                mcnt++;
            end
            tick();
            if (read_s) begin
                checks++;
                if (data_out !== exp_q) begin
                    errors++;
                    $display("FAIL periodic_read%0d: got %h expected %h", reads, data_out, exp_q);
                end
                checks++;
                if (data_out[CW-1:0] !== 8'd37 && data_out[CW-1:0] !== 8'd38) begin
                    errors++;
                    $display("FAIL periodic_npt%0d: got %0d expected 37 or 38", reads, data_out[CW-1:0]);
                end
                hand_avg = (data_out[CW-1:0] == 8'd38) ? 24'd13194 : 24'd12847;
                checks++;
                if (data_out[DW+CW-1:CW] !== hand_avg) begin
                    errors++;
                    $display("FAIL periodic_avg%0d: got %0d expected %0d", reads, data_out[DW+CW-1:CW], hand_avg);
                end
                if (reads > 0 && data_out[CW-1:0] != prev_npt) begin
                    checks++;
                    if (data_out[DW+CW-1:CW] === prev_avg) begin
                        errors++;
                        $display("FAIL periodic_avg_tracks_npt%0d: got %0d expected not %0d", reads, data_out[DW+CW-1:CW], prev_avg);
                    end
                end
                prev_avg = data_out[DW+CW-1:CW];
                prev_npt = data_out[CW-1:0];
                reads++;
            end
        end
        data_s = 1'b0; read_s = 1'b0;
    endtask

    task automatic test_saturation();
        logic [DW+CW-1:0] exp_sat;
`ifdef HOST_AVERAGER_ROUND_EN
        exp_sat = pack(24'd88541, 8'd255);
`else
        exp_sat = pack(24'd88540, 8'd255);
`endif
        do_read();
        for (int c = 0; c < 1400; c++) begin
            data_in = 24'd88888;
            data_s  = (c % 5 == 0);
            tick();
        end
        do_read();
        checks++;
        if (data_out !== exp_sat) begin
            errors++;
            $display("FAIL saturation: got %h expected %h", data_out, exp_sat);
        end
        for (int c = 0; c < 20; c++) sample(24'd100);
        checks++;
        if (data_out !== exp_sat) begin
            errors++;
            $display("FAIL saturation_hold: got %h expected %h", data_out, exp_sat);
        end
    endtask

    task automatic test_same_cycle();
        logic [DW+CW-1:0] exp_b;
        do_read();
        sample(24'd1000);
        sample(24'd2000);
        sample(24'd3000);
        data_in = 24'd5000; data_s = 1'b1; read_s = 1'b1;
        tick();
        data_s = 1'b0; read_s = 1'b0;
        checks++;
        if (data_out !== pack(24'd23, 8'd3)) begin
            errors++;
            $display("FAIL same_cycle_excluded: got %h expected %h", data_out, pack(24'd23, 8'd3));
        end
        sample(24'd7000);
        do_read();
`ifdef HOST_AVERAGER_ROUND_EN
        exp_b = pack(24'd47, 8'd2);
`else
        exp_b = pack(24'd46, 8'd2);
`endif
        checks++;
        if (data_out !== exp_b) begin
            errors++;
            $display("FAIL same_cycle_carried: got %h expected %h", data_out, exp_b);
        end
    endtask

    task automatic test_back_to_back();
        sample(24'd512);
        sample(24'd512);
        do_read();
        checks++;
        if (data_out !== pack(24'd4, 8'd2)) begin
            errors++;
            $display("FAIL b2b_first: got %h expected %h", data_out, pack(24'd4, 8'd2));
        end
        do_read();
        checks++;
        if (data_out !== '0) begin
            errors++;
            $display("FAIL b2b_second: got %h expected %h", data_out, {(DW+CW){1'b0}});
        end
    endtask

    task automatic test_async_reset();
        sample(24'd256);
        sample(24'd256);
        sample(24'd256);
        do_read();
        checks++;
        if (data_out !== pack(24'd3, 8'd3)) begin
            errors++;
            $display("FAIL pre_reset_read: got %h expected %h", data_out, pack(24'd3, 8'd3));
        end
        sample(24'd256);
        sample(24'd256);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (data_out !== '0) begin
            errors++;
            $display("FAIL async_reset_clear: got %h expected %h", data_out, {(DW+CW){1'b0}});
        end
        tick();
        rst = 1'b0;
        tick();
        sample(24'd256);
        sample(24'd256);
        do_read();
        checks++;
        if (data_out !== pack(24'd2, 8'd2)) begin
            errors++;
            $display("FAIL post_reset_read: got %h expected %h", data_out, pack(24'd2, 8'd2));
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_saturation();
        test_same_cycle();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
